alu_serial_ctrl: RTL and testbench

Bit-serial sequencer for the 1-bit ALU slice (module ALU: M[2:0], a, b, c -> out, next).
- Accepts W-bit operands and a mode, then drives the slice LSB-first for W cycles.
- Feeds `next` back as the carry through an internal flop and assembles the W-bit result.
- Sits between a requester (start/done handshake) and one externally instantiated ALU slice.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_serial_shreg.sv | 28 ++
 rtl/alu_serial_ctrl.sv | 151 +++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the bit-serial ALU sequencer.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_XNOR = 3'b100;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Codes above OP_XNOR have no slice function.
  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_XNOR);
  endfunction

endpackage

// File: rtl/alu_serial_shreg.sv
// W-bit register with parallel load and shift-right, serial data entering at the MSB.
module alu_serial_shreg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         shift_i,
  input  logic         sin_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= load_val_i;
    end else if (shift_i) begin
      q_q <= {sin_i, q_q[W-1:1]};
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/alu_serial_ctrl.sv
// Drives an external 1-bit ALU slice LSB-first for W cycles and assembles the W-bit result.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] opb,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] result,
  output logic         cout,
  output logic [2:0]   alu_m,
  output logic         alu_a,
  output logic         alu_b,
  output logic         alu_c,
  input  logic         alu_out,
  input  logic         alu_next
);

  localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [2:0]       m_q, m_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;
  logic             load_c, shift_c;
  logic [W-1:0]     a_q, b_q;

  alu_serial_shreg #(.W(W)) u_a_sh (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_c),
    .load_val_i (opa),
    .shift_i    (shift_c),
    .sin_i      (1'b0),
    .q_o        (a_q)
  );

  alu_serial_shreg #(.W(W)) u_b_sh (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_c),
    .load_val_i (opb),
    .shift_i    (shift_c),
    .sin_i      (1'b0),
    .q_o        (b_q)
  );

  // Result is never loaded; W shifts fully replace it, so it holds between runs.
  alu_serial_shreg #(.W(W)) u_res_sh (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (1'b0),
    .load_val_i ('0),
    .shift_i    (shift_c),
    .sin_i      (alu_out),
    .q_o        (result)
  );

  logic unused_sh_bits;
  assign unused_sh_bits = ^{a_q[W-1:1], b_q[W-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      m_q     <= 3'b000;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      m_q     <= m_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    m_d     = m_q;
    cout_d  = cout_q;
    err_d   = err_q;
    load_c  = 1'b0;
    shift_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op_legal(op)) begin
            load_c  = 1'b1;
            m_d     = op;
            carry_d = (op == OP_ADD) & cin;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = ST_RUN;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        shift_c = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (m_q == OP_ADD) begin
          carry_d = alu_next;
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          cout_d  = (m_q == OP_ADD) & alu_next;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // err is only meaningful alongside done.
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  logic in_run_c;
  assign in_run_c = (state_q == ST_RUN);

  assign busy  = in_run_c;
  assign done  = (state_q == ST_DONE);
  assign err   = err_q;
  assign cout  = cout_q;
  assign alu_m = in_run_c ? m_q : 3'b000;
  assign alu_a = in_run_c & a_q[0];
  assign alu_b = in_run_c & b_q[0];
  assign alu_c = in_run_c & (m_q == OP_ADD) & carry_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench: behavioural ALU slice wired to the sequencer, hand-computed vectors.
module tb_alu_serial_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic         cin = 1'b0;
  logic         busy, done, err, cout;
  logic [W-1:0] result;
  logic [2:0]   alu_m;
  logic         alu_a, alu_b, alu_c, alu_out, alu_next;

  int total = 0;
  int passed = 0;

  alu_serial_ctrl #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .opa      (opa),
    .opb      (opb),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .result   (result),
    .cout     (cout),
    .alu_m    (alu_m),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_c    (alu_c),
    .alu_out  (alu_out),
    .alu_next (alu_next)
  );

  always #5 clk = ~clk;

  // 1-bit slice model
  always_comb begin
    alu_out  = 1'b0;
    alu_next = 1'b0;
    case (alu_m)
      3'b000: begin
        alu_out  = alu_a ^ alu_b ^ alu_c;
        alu_next = (alu_a & alu_b) | (alu_a & alu_c) | (alu_b & alu_c);
      end
      3'b001: alu_out = alu_a & alu_b;
      3'b010: alu_out = alu_a | alu_b;
      3'b011: alu_out = alu_a ^ alu_b;
      3'b100: alu_out = ~(alu_a ^ alu_b);
      default: alu_out = 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic c, input logic [W-1:0] er,
                        input logic ec, input logic ee, input int ebusy);
    int nb;
    int guard;
    @(negedge clk);
    op = o; opa = a; opb = b; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (ebusy > 0) chk({tag, "_alu_m"}, 32'(alu_m), 32'(o));
    nb = 0;
    guard = 0;
    while (!done && guard < 40) begin
      if (busy) nb++;
      guard++;
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(nb), 32'(ebusy));
    chk({tag, "_result"}, 32'(result), 32'(er));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_err"}, 32'(err), 32'(ee));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle_alu"}, 32'({alu_m, alu_a, alu_b, alu_c, busy, err}), 32'd0);
  endtask

  initial begin
    #3;
    chk("rst_outputs", 32'({busy, done, err, cout, alu_m, alu_a, alu_b, alu_c}), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add1", 3'b000, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0, 8);
    run_op("add2", 3'b000, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 8);
    run_op("and",  3'b001, 8'hA5, 8'h0F, 1'b1, 8'h05, 1'b0, 1'b0, 8);
    run_op("or",   3'b010, 8'hA5, 8'h0F, 1'b1, 8'hAF, 1'b0, 1'b0, 8);
    run_op("xor",  3'b011, 8'hF0, 8'h3C, 1'b1, 8'hCC, 1'b0, 1'b0, 8);
    run_op("xnor", 3'b100, 8'hF0, 8'h3C, 1'b0, 8'h33, 1'b0, 1'b0, 8);
    run_op("ill",  3'b110, 8'h12, 8'h34, 1'b0, 8'h33, 1'b0, 1'b1, 0);

    // First RUN cycle of a carry-in add: slice sees a=1, b=1, c=cin.
    @(negedge clk);
    op = 3'b000; opa = 8'hFF; opb = 8'h01; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("drive_bit0", 32'({alu_a, alu_b, alu_c}), 32'b111);
    repeat (10) @(negedge clk);

    // Start held through RUN and DONE with operands changing mid-run.
    op = 3'b000; opa = 8'h5A; opb = 8'h3C; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    opa = 8'hFF; opb = 8'hFF; op = 3'b011;
    begin
      int guard = 0;
      while (!done && guard < 40) begin
        guard++;
        @(negedge clk);
      end
    end
    chk("held_done", 32'(done), 32'd1);
    chk("held_result", 32'(result), 32'h96);
    start = 1'b0;
    begin
      int extra = 0;
      repeat (12) begin
        @(negedge clk);
        if (done || busy) extra++;
      end
      chk("held_no_second", 32'(extra), 32'd0);
    end

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    op = 3'b000; opa = 8'hFF; opb = 8'h00; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("prerst_busy_a", 32'({busy, alu_a}), 32'b11);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", 32'({busy, done, err, cout, alu_m, alu_a, alu_b, alu_c}), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("post_rst_add", 3'b000, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
